// File: rtl/map_read_arbiter_pkg.sv
// map_read_arbiter_pkg
//   Map geometry, pixel codes and small helpers shared by the map read
//   arbiter and the ball movers.
//   Contents:
//     COORD_W / PIX_W      coordinate and pixel widths
//     MAP_COLS / MAP_ROWS  playfield size
//     pixel_e              map pixel codes (WALL, HOLE, WIN)
//     is_oob()             out-of-range test for a col/row pair
package map_read_arbiter_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned PIX_W    = 8;

    localparam int unsigned MAP_COLS = 640;
    localparam int unsigned MAP_ROWS = 480;

    typedef enum logic [PIX_W-1:0] {
        PIX_WALL = 8'h26,
        PIX_HOLE = 8'h49,
        PIX_WIN  = 8'hF9
    } pixel_e;

    // Unsigned compare against the playfield size; coordinates outside the
    // map read back as a wall so movers never escape the playfield.
    function automatic logic is_oob(
        input logic [COORD_W-1:0] col,
        input logic [COORD_W-1:0] row,
        input int unsigned        cols,
        input int unsigned        rows
    );
        return (32'(col) >= cols) || (32'(row) >= rows);
    endfunction

endpackage

// File: rtl/map_read_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Searches req starting at ptr+1
//   (wrapping at N-1) and reports the first requester found.
//   Ports:
//     req    in  N  request vector
//     ptr    in  W  index of the previous winner
//     grant  out N  one-hot winner (all zero when nothing requests)
//     idx    out W  binary index of the winner
//     found  out 1  any requester selected
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = ptr;
        for (int unsigned k = 0; k < N; k++) begin
            // Explicit wrap keeps the search inside 0..N-1 for non-power-of-2 N.
            cand = (cand == W'(N - 1)) ? '0 : cand + W'(1);
            if (!found && req[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/map_read_arbiter.sv
// map_read_arbiter
//   Shares the collision read port (port A) of the map ROM between N_REQ
//   requesters. One round-robin grant per cycle; each response returns to
//   its own requester, in grant order, READ_LATENCY+2 cycles after grant.
//   Ports:
//     clk           in   1        system clock
//     reset         in   1        asynchronous active-low reset
//     req_valid     in   N_REQ    requester i wants a read (held until granted)
//     req_col       in   10*N_REQ column of requester i at [10*i +: 10]
//     req_row       in   10*N_REQ row of requester i at [10*i +: 10]
//     req_grant     out  N_REQ    one-hot, combinational accept
//     rsp_valid     out  N_REQ    one-hot, registered 1-cycle response pulse
//     rsp_data      out  8        pixel value, or OOB_VALUE when out of range
//     map_col_addr  out  10       registered column to map port A
//     map_row_addr  out  10       registered row to map port A
//     map_data      in   8        map port A data
//     busy          out  1        any read in flight
module map_read_arbiter
    import map_read_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAP_COLS     = map_read_arbiter_pkg::MAP_COLS,
    parameter int unsigned MAP_ROWS     = map_read_arbiter_pkg::MAP_ROWS,
    parameter logic [7:0]  OOB_VALUE    = PIX_WALL
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [10*N_REQ-1:0]     req_col,
    input  logic [10*N_REQ-1:0]     req_row,
    output logic [N_REQ-1:0]        req_grant,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [7:0]              rsp_data,
    output logic [9:0]              map_col_addr,
    output logic [9:0]              map_row_addr,
    input  logic [7:0]              map_data,
    output logic                    busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned LAST  = READ_LATENCY;

    logic [IDX_W-1:0]  rr_ptr;
    logic [N_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic              grant_fire;

    logic [9:0]        sel_col;
    logic [9:0]        sel_row;
    logic              sel_oob;

    // Tag stage k holds the read granted k+1 cycles ago; the last stage lines
    // up with valid map_data for that read.
    logic [LAST:0]     tag_valid;
    logic [LAST:0]     tag_oob;
    logic [IDX_W-1:0]  tag_id [LAST+1];

    rr_pick #(
        .N (N_REQ),
        .W (IDX_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Grants are suppressed while reset is asserted.
    always_comb begin
        req_grant  = reset ? pick_grant : '0;
        grant_fire = reset & pick_found;
    end

    always_comb begin
        sel_col = '0;
        sel_row = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_col = req_col[10*i +: 10];
                sel_row = req_row[10*i +: 10];
            end
        end
        sel_oob = is_oob(sel_col, sel_row, MAP_COLS, MAP_ROWS);
    end

    // Round-robin pointer and issue address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr       <= IDX_W'(N_REQ - 1);
            map_col_addr <= '0;
            map_row_addr <= '0;
        end else if (grant_fire) begin
            rr_ptr       <= pick_idx;
            map_col_addr <= sel_col;
            map_row_addr <= sel_row;
        end
    end

    // Tag shift register, advanced every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid <= '0;
            tag_oob   <= '0;
            for (int unsigned k = 0; k <= LAST; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_valid[0] <= grant_fire;
            tag_oob[0]   <= sel_oob;
            tag_id[0]    <= pick_idx;
            for (int unsigned k = 1; k <= LAST; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_oob[k]   <= tag_oob[k-1];
                tag_id[k]    <= tag_id[k-1];
            end
        end
    end

    // Response registers; rsp_data holds its last value between pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (tag_valid[LAST]) begin
            rsp_valid <= N_REQ'(1) << tag_id[LAST];
            rsp_data  <= tag_oob[LAST] ? OOB_VALUE : map_data;
        end else begin
            rsp_valid <= '0;
        end
    end

    assign busy = |tag_valid;

endmodule

// File: tb/tb_map_read_arbiter.sv
module tb_map_read_arbiter;
    import map_read_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int RL = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [10*N-1:0]  req_col = '0;
    logic [10*N-1:0]  req_row = '0;
    logic [N-1:0]     req_grant;
    logic [N-1:0]     rsp_valid;
    logic [7:0]       rsp_data;
    logic [9:0]       map_col_addr;
    logic [9:0]       map_row_addr;
    logic [7:0]       map_data;
    logic             busy;

    map_read_arbiter #(
        .N_REQ        (N),
        .READ_LATENCY (RL),
        .MAP_COLS     (640),
        .MAP_ROWS     (480),
        .OOB_VALUE    (8'h26)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_col      (req_col),
        .req_row      (req_row),
        .req_grant    (req_grant),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .map_col_addr (map_col_addr),
        .map_row_addr (map_row_addr),
        .map_data     (map_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Map port A model: pixel pattern chosen so (100,50) reads 8'h00.
    function automatic logic [7:0] pix(input logic [9:0] c, input logic [9:0] r);
        return c[7:0] ^ r[7:0] ^ {c[9:8], r[9:8], 4'h0} ^ 8'h56;
    endfunction

    logic [7:0] map_pipe [RL];
    initial for (int k = 0; k < RL; k++) map_pipe[k] = '0;
    always @(posedge clk) begin
        map_pipe[0] <= pix(map_col_addr, map_row_addr);
        for (int k = 1; k < RL; k++) map_pipe[k] <= map_pipe[k-1];
    end
    assign map_data = map_pipe[RL-1];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected responses queued with their due cycle.
    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t         q[$];
    int           m_ptr = N - 1;
    int           cyc = 0;
    logic [N-1:0] last_eg = '0;

    task automatic model_check();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         eb;
        logic [9:0]   c;
        logic [9:0]   r;
        int           gi;
        exp_t         e;
        eg = '0;
        er = '0;
        eb = 1'b0;
        gi = -1;
        if (reset) begin
            for (int k = 1; k <= N; k++) begin
                int cand;
                cand = (m_ptr + k) % N;
                if (gi < 0 && req_valid[cand]) gi = cand;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        chk("grant", 32'(req_grant), 32'(eg));
        if (gi >= 0) begin
            c = req_col[gi*10 +: 10];
            r = req_row[gi*10 +: 10];
            e.due  = cyc + RL + 2;
            e.id   = gi;
            e.data = (c >= 10'd640 || r >= 10'd480) ? 8'h26 : pix(c, r);
            q.push_back(e);
            m_ptr = gi;
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            er[q[0].id] = 1'b1;
            chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
            void'(q.pop_front());
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(er));
        foreach (q[i]) if (cyc >= q[i].due - RL - 1 && cyc <= q[i].due - 1) eb = 1'b1;
        chk("busy", 32'(busy), 32'(eb));
        last_eg = eg;
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic set_addr(input int i, input int c, input int r);
        req_col[i*10 +: 10] = 10'(c);
        req_row[i*10 +: 10] = 10'(r);
    endtask

    task automatic drain();
        req_valid = '0;
        for (int k = 0; k < RL + 4; k++) step();
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_grant", 32'(req_grant), 32'(0));
        q.delete();
        m_ptr = N - 1;
        step();
        step();
        reset = 1'b1;
    endtask

    // Single read from requester 0; checks exact response cycle and data.
    task automatic single_read(input string name, input int c, input int r, input logic [7:0] exp);
        set_addr(0, c, r);
        req_valid = 4'b0001;
        sample();
        chk({name, "_grant"}, 32'(req_grant), 32'(4'b0001));
        advance();
        req_valid = '0;
        for (int k = 1; k < RL + 2; k++) begin
            sample();
            chk({name, "_early"}, 32'(rsp_valid), 32'(0));
            advance();
        end
        sample();
        chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'(4'b0001));
        chk({name, "_rsp_data"}, 32'(rsp_data), 32'(exp));
        advance();
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] grant;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [9:0]   hold_c;
        logic [9:0]   hold_r;
        logic [N-1:0] act;

        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1010, 4'b1000};
        tbl[3]  = '{4'b1010, 4'b0010};
        tbl[4]  = '{4'b1010, 4'b1000};
        tbl[5]  = '{4'b0000, 4'b0000};
        tbl[6]  = '{4'b0100, 4'b0100};
        tbl[7]  = '{4'b0101, 4'b0001};
        tbl[8]  = '{4'b0101, 4'b0100};
        tbl[9]  = '{4'b0001, 4'b0001};
        tbl[10] = '{4'b0001, 4'b0001};
        tbl[11] = '{4'b1001, 4'b1000};
        tbl[12] = '{4'b1110, 4'b0010};
        tbl[13] = '{4'b1110, 4'b0100};
        tbl[14] = '{4'b1110, 4'b1000};

        // Power-up reset.
        #1;
        chk("por_busy", 32'(busy), 32'(0));
        chk("por_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("por_rsp_data", 32'(rsp_data), 32'(0));
        chk("por_col_addr", 32'(map_col_addr), 32'(0));
        chk("por_row_addr", 32'(map_row_addr), 32'(0));
        chk("por_grant", 32'(req_grant), 32'(0));
        step();
        step();
        reset = 1'b1;

        // All four requesting continuously: 0,1,2,3,0,...
        for (int i = 0; i < N; i++) set_addr(i, 10 * i + 5, 20 * i + 3);
        req_valid = '1;
        for (int i = 0; i < 2 * N; i++) begin
            sample();
            chk("rr_all", 32'(req_grant), 32'(1) << (i % N));
            advance();
        end
        drain();

        // Arbitration table from a fresh reset (pointer starts at N-1).
        assert_reset();
        for (int i = 0; i < 15; i++) begin
            req_valid = tbl[i].req;
            sample();
            chk("tbl_grant", 32'(req_grant), 32'(tbl[i].grant));
            advance();
        end
        drain();

        // Single read latency and out-of-range reads.
        single_read("single", 100, 50, 8'h00);
        single_read("oob_col", 640, 10, 8'h26);
        single_read("oob_row", 5, 480, 8'h26);
        single_read("edge_in", 639, 479, pix(10'd639, 10'd479));
        drain();

        // Idle: nothing moves, address registers hold.
        hold_c = map_col_addr;
        hold_r = map_row_addr;
        for (int k = 0; k < 10; k++) begin
            sample();
            chk("idle_col_addr", 32'(map_col_addr), 32'(hold_c));
            chk("idle_row_addr", 32'(map_row_addr), 32'(hold_r));
            advance();
        end

        // Three reads in flight, then reset: nothing is delivered.
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) step();
        req_valid = '0;
        step();
        assert_reset();
        for (int k = 0; k < RL + 4; k++) begin
            sample();
            chk("flush_rsp", 32'(rsp_valid), 32'(0));
            advance();
        end
        req_valid = '1;
        sample();
        chk("post_rst_grant", 32'(req_grant), 32'(4'b0001));
        advance();
        drain();

        // Randomized traffic with holds, cancels and out-of-range addresses.
        act = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < N; i++) begin
                if (last_eg[i] || !act[i]) begin
                    act[i] = ($urandom_range(0, 1) == 1);
                    set_addr(i, int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
                end else if ($urandom_range(0, 15) == 0) begin
                    act[i] = 1'b0;
                end
            end
            req_valid = act;
            step();
        end
        drain();
        chk("final_queue_empty", 32'(q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
